// File: rtl/axi_axis_rd_sched.sv
// AXI4 read-master scheduler: splits a beat-count transfer into INCR bursts and streams R beats to AXIS. Optional macro: AXI_AXIS_RD_SCHED_ERR_EN.
// Latency: zero-latency R->AXIS pass-through; backpressure: m_axis_tready drives m_axi_rready directly, no buffering.
module axi_axis_rd_sched #(
  parameter int G_AXI_DATAWIDTH = 32,
  parameter int G_ADDR_WIDTH    = 10,
  parameter int G_ID_WIDTH      = 4,
  parameter int G_ARID          = 0,
  parameter int G_MAX_BURST     = 16,
  parameter int G_LEN_WIDTH     = 16
) (
  input  logic                       s_aclk,
  input  logic                       s_aresetn,
  input  logic                       start,
  input  logic [G_ADDR_WIDTH-1:0]    base_addr,
  input  logic [G_LEN_WIDTH-1:0]     num_beats,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [G_ID_WIDTH-1:0]      m_axi_arid,
  output logic [G_ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [G_ID_WIDTH-1:0]      m_axi_rid,
  input  logic [G_AXI_DATAWIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  output logic [G_AXI_DATAWIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready
);

  localparam int BYTES = G_AXI_DATAWIDTH / 8;
  localparam logic [G_ADDR_WIDTH-1:0] ADDR_INC = G_ADDR_WIDTH'(BYTES);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                  state, state_nxt;
  logic [G_ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [G_LEN_WIDTH-1:0]  remaining, rem_nxt;
  logic [8:0]              bcnt, bcnt_nxt;
  logic [7:0]              arlen_q, len_nxt;
  logic                    beat;

  assign beat = (state == DATA) && m_axi_rvalid && m_axis_tready;

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      bcnt      <= '0;
      arlen_q   <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= rem_nxt;
      bcnt      <= bcnt_nxt;
      // burst length is frozen on entry so AR stays stable until accepted
      if (state_nxt == ADDR && state != ADDR)
        arlen_q <= len_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rem_nxt   = remaining;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE: begin
        if (start) begin
          addr_nxt  = base_addr;
          rem_nxt   = num_beats;
          state_nxt = (num_beats == '0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          bcnt_nxt  = 9'(arlen_q) + 9'd1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          rem_nxt  = remaining - 1'b1;
          addr_nxt = addr + ADDR_INC;
          bcnt_nxt = bcnt - 9'd1;
          // burst boundary comes from our own count, rlast is not trusted
          if (bcnt == 9'd1)
            state_nxt = (remaining == {{(G_LEN_WIDTH-1){1'b0}}, 1'b1}) ? DONE : ADDR;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    len_nxt = 8'(G_MAX_BURST - 1);
    if (32'(rem_nxt) < G_MAX_BURST)
      len_nxt = 8'(rem_nxt - 1'b1);
  end

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign m_axi_arid    = G_ID_WIDTH'(G_ARID);
  assign m_axi_araddr  = addr;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'($clog2(BYTES));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state == ADDR);
  assign m_axi_rready  = (state == DATA) && m_axis_tready;
  assign m_axis_tvalid = (state == DATA) && m_axi_rvalid;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = (state == DATA) && (remaining == {{(G_LEN_WIDTH-1){1'b0}}, 1'b1});

`ifdef AXI_AXIS_RD_SCHED_ERR_EN
  logic err_q;
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn)
      err_q <= 1'b0;
    else if (state == IDLE && start)
      err_q <= 1'b0;
    else if (beat && (m_axi_rresp != 2'b00 || m_axi_rlast != (bcnt == 9'd1)))
      err_q <= 1'b1;
  end
  assign err = err_q;
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;
`else
  assign err = 1'b0;
  logic unused_in;
  assign unused_in = ^{m_axi_rid, m_axi_rresp, m_axi_rlast};
`endif

endmodule

// File: tb/tb_axi_axis_rd_sched.sv
// Scoreboard bench for axi_axis_rd_sched: driver queues expected AR/AXIS traffic, a monitor checks it.
module tb_axi_axis_rd_sched;
  localparam int DW = 32, AW = 10, IW = 4, LW = 16;
`ifdef AXI_AXIS_RD_SCHED_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] num_beats;
  logic          busy, done, err;
  logic [IW-1:0] m_axi_arid, m_axi_rid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst, m_axi_rresp;
  logic          m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axi_rdata, m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;

  axi_axis_rd_sched dut (
    .s_aclk(clk), .s_aresetn(rst_n), .start(start), .base_addr(base_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .err(err),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [AW-1:0] addr; logic [7:0] len;} ar_t;
  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  ar_t   ar_q[$];
  beat_t exp_q[$];
  int checks = 0, fails = 0, beats_seen = 0;
  int tag = 0, tmode = 0, err_beat = -1, xfer_beat = 0;

  function automatic logic [DW-1:0] mk_data(input int t, input logic [AW-1:0] a);
    return {8'hDA, 8'(t), 6'b0, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // memory-side responder: random arready, random rvalid gaps, data tagged by address
  initial begin
    logic [AW-1:0] cur, ar_a;
    logic [7:0]    ar_l;
    logic          ar_hs, r_hs;
    logic [3:0]    pat;
    int            left, cyc;
    cur = '0; ar_a = '0; ar_l = '0; ar_hs = 0; r_hs = 0; pat = 4'b1001; left = 0; cyc = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rlast = 0; m_axi_rid = '0; m_axis_tready = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        left = 0; ar_hs = 0; r_hs = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
      end else begin
        if (ar_hs) begin cur = ar_a; left = int'(ar_l) + 1; end
        if (r_hs) begin cur = cur + AW'(4); left--; xfer_beat++; end
        m_axi_arready = m_axi_arvalid && left == 0 && ($urandom_range(0, 1) == 1);
        if (!(m_axi_rvalid && !r_hs))
          m_axi_rvalid = left > 0 && ($urandom_range(0, 3) != 0);
        m_axi_rdata = mk_data(tag, cur);
        m_axi_rlast = (left == 1);
        m_axi_rresp = (xfer_beat == err_beat) ? 2'b10 : 2'b00;
      end
      m_axis_tready = (tmode == 0) ? 1'b1 : pat[cyc % 4];
      #1;
      ar_hs = m_axi_arvalid && m_axi_arready;
      ar_a  = m_axi_araddr;
      ar_l  = m_axi_arlen;
      r_hs  = m_axi_rvalid && m_axi_rready;
    end
  end

  // monitor: pops expectations whenever the DUT presents a handshake
  initial begin
    logic pv, pr;
    logic [AW-1:0] pa;
    pv = 0; pr = 0; pa = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (pv && !pr) begin
          chk("ar_hold_valid", m_axi_arvalid, 1);
          chk("ar_hold_addr", m_axi_araddr, pa);
        end
        if (m_axi_arvalid) begin
          chk("ar_expected", ar_q.size() > 0, 1);
          if (m_axi_arready && ar_q.size() > 0) begin
            ar_t e;
            e = ar_q.pop_front();
            chk("araddr", m_axi_araddr, e.addr);
            chk("arlen", m_axi_arlen, e.len);
            chk("arsize", m_axi_arsize, 2);
            chk("arburst", m_axi_arburst, 1);
            chk("arid", m_axi_arid, 0);
          end
        end
        if (m_axi_rvalid || m_axis_tvalid) begin
          chk("rready_tracks_tready", m_axi_rready, m_axis_tready);
          chk("tvalid_passthru", m_axis_tvalid, m_axi_rvalid);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_beat: got data %0h, expected no beat", m_axis_tdata);
          end else begin
            beat_t b;
            b = exp_q.pop_front();
            chk("tdata", m_axis_tdata, b.data);
            chk("tlast", m_axis_tlast, b.last);
          end
        end
      end
      pv = m_axi_arvalid && rst_n;
      pr = m_axi_arready;
      pa = m_axi_araddr;
    end
  end

  task automatic expect_xfer(input logic [AW-1:0] base, input int n);
    int rem;
    logic [AW-1:0] a;
    rem = n; a = base;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = mk_data(tag, AW'(int'(base) + 4 * i));
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    while (rem > 0) begin
      int l;
      ar_t r;
      l = (rem > 16) ? 16 : rem;
      r.addr = a; r.len = 8'(l - 1);
      ar_q.push_back(r);
      a = a + AW'(4 * l);
      rem -= l;
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input int n);
    @(negedge clk);
    #3;
    xfer_beat = 0;
    base_addr = base; num_beats = LW'(n); start = 1;
    @(negedge clk);
    #3;
    start = 0;
  endtask

  task automatic wait_done(input string nm, input int budget, input logic mid, input logic exp_err);
    int cyc;
    cyc = 0;
    chk({nm, "_busy_running"}, busy, 1);
    while (!done && cyc < budget) begin
      @(negedge clk);
      #3;
      cyc++;
      if (mid && cyc == 20) begin
        base_addr = 10'h200; num_beats = 5; start = 1;
      end else start = 0;
    end
    start = 0;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_err_at_done"}, err, exp_err);
    @(negedge clk);
    #3;
    chk({nm, "_done_one_cycle"}, done, 0);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_err_sticky"}, err, exp_err);
    chk({nm, "_beats_left"}, exp_q.size(), 0);
    chk({nm, "_ars_left"}, ar_q.size(), 0);
    exp_q.delete();
    ar_q.delete();
  endtask

  initial begin
    int b0, c;
    start = 0; base_addr = '0; num_beats = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    rst_n = 1;

    tag = 1; expect_xfer(10'h000, 8);
    pulse_start(10'h000, 8);
    wait_done("single_burst", 2000, 0, 0);

    tag = 2; expect_xfer(10'h000, 40);
    pulse_start(10'h000, 40);
    wait_done("three_bursts_midstart", 2000, 1, 0);

    tag = 3;
    pulse_start(10'h100, 0);
    chk("zero_done_next_cycle", done, 1);
    chk("zero_busy", busy, 1);
    @(negedge clk);
    #3;
    chk("zero_done_cleared", done, 0);
    chk("zero_busy_after", busy, 0);

    tag = 4; tmode = 1; expect_xfer(10'h3F0, 20);
    pulse_start(10'h3F0, 20);
    wait_done("wrap_tready_toggle", 3000, 0, 0);
    tmode = 0;

    tag = 5; expect_xfer(10'h100, 40);
    b0 = beats_seen; c = 0;
    pulse_start(10'h100, 40);
    while (beats_seen < b0 + 5 && c < 500) begin
      @(negedge clk);
      #3;
      c++;
    end
    chk("reset_mid_reached", beats_seen >= b0 + 5, 1);
    rst_n = 0;
    #1;
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_arvalid", m_axi_arvalid, 0);
    chk("reset_mid_tvalid", m_axis_tvalid, 0);
    chk("reset_mid_done", done, 0);
    exp_q.delete();
    ar_q.delete();
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1;

    tag = 6; expect_xfer(10'h080, 12);
    pulse_start(10'h080, 12);
    wait_done("after_reset", 2000, 0, 0);

    tag = 7; err_beat = 2; expect_xfer(10'h000, 8);
    pulse_start(10'h000, 8);
    wait_done("rresp_err", 2000, 0, EXP_ERR);
    err_beat = -1;

    tag = 8; expect_xfer(10'h040, 3);
    pulse_start(10'h040, 3);
    chk("err_cleared_by_start", err, 0);
    wait_done("post_err", 2000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
